// File: rtl/adc_controller.sv
// adc_controller: continuous round-robin sampler for an ADC128S022-type
// 8-channel, 12-bit serial ADC. Converts channels 5, 6 and 7 in turn and
// keeps the latest result of each in its own output register.
//
// Ports
//   clk_50M      in   50 MHz system clock, all flops on its rising edge
//   rst_n        in   asynchronous active-low reset
//   dout         in   serial data from the ADC
//   adc_sck      out  1 MHz SPI clock (25 cycles high / 25 cycles low)
//   adc_cs_n     out  chip select, low from the first sck fall onward
//   din          out  serial control word (channel address) to the ADC
//   left_value   out  latest channel-5 result
//   center_value out  latest channel-6 result
//   right_value  out  latest channel-7 result

// One output holding register per converted channel.
module adc_chan_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [11:0] data,
  output logic [11:0] value
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  value <= '0;
    else if (wr) value <= data;
endmodule

module adc_controller #(
  parameter int          NUM_CH   = 3,
  parameter logic [2:0]  FIRST_CH = 3'd5
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        dout,
  output logic        adc_sck,
  output logic        adc_cs_n,
  output logic        din,
  output logic [11:0] left_value,
  output logic [11:0] center_value,
  output logic [11:0] right_value
);
  localparam logic [2:0] LAST_CH = FIRST_CH + 3'(NUM_CH - 1);

  // ---------------- clock scaler ----------------
  logic [4:0] scl_cnt;
  logic       sck_rise, sck_fall;

  // Strobes are high in the cycle whose closing edge toggles adc_sck.
  assign sck_rise = (scl_cnt == 5'd24) & ~adc_sck;
  assign sck_fall = (scl_cnt == 5'd24) &  adc_sck;

  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      scl_cnt <= '0;
      adc_sck <= 1'b0;
    end else if (scl_cnt == 5'd24) begin
      scl_cnt <= '0;
      adc_sck <= ~adc_sck;
    end else begin
      scl_cnt <= scl_cnt + 5'd1;
    end

  // ---------------- chip-select FSM ----------------
  typedef enum logic {ST_IDLE, ST_CONV} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sck_fall) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_CONV;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cs_n comes straight from the state flop, so it drops on the same edge
  // as the first sck fall and never glitches.
  assign adc_cs_n = (state == ST_IDLE);

  // ---------------- serial datapath ----------------
  logic        active;
  logic [3:0]  bit_idx;
  logic [10:0] shreg;
  logic [2:0]  addr, prev_addr;
  logic        first;
  logic [15:0] ctrl_word;
  logic [11:0] word;
  logic        frame_end;

  assign active    = (state == ST_CONV);
  assign ctrl_word = {2'b00, addr, 11'd0};
  // Bit n=15 is still on dout at the final rise, so it joins the word here.
  assign word      = {shreg, dout};
  assign frame_end = sck_rise & active & (bit_idx == 4'd15);

  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      bit_idx   <= '0;
      din       <= 1'b0;
      shreg     <= '0;
      addr      <= FIRST_CH;
      prev_addr <= FIRST_CH;
      first     <= 1'b1;
    end else begin
      // The first fall (cs_n dropping) already presents bit 15 with n=0.
      if (sck_fall) din <= ctrl_word[~bit_idx];
      if (sck_rise && active) begin
        bit_idx <= bit_idx + 4'd1;
        // n=0..3 are the ADC's leading zero slots and are not captured.
        if (bit_idx >= 4'd4) shreg <= {shreg[9:0], dout};
      end
      // Data in a frame answers the address sent in the previous frame.
      if (frame_end) begin
        first     <= 1'b0;
        prev_addr <= addr;
        addr      <= (addr == LAST_CH) ? FIRST_CH : addr + 3'd1;
      end
    end

  // ---------------- per-channel output registers ----------------
  logic [NUM_CH-1:0]       wr;
  logic [NUM_CH-1:0][11:0] chan_val;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = frame_end & ~first & (prev_addr == FIRST_CH + 3'(i));
    adc_chan_reg u_reg (
      .clk   (clk_50M),
      .rst_n (rst_n),
      .wr    (wr[i]),
      .data  (word),
      .value (chan_val[i])
    );
  end

  assign left_value   = chan_val[0];
  assign center_value = chan_val[1];
  assign right_value  = chan_val[2];
endmodule

// File: tb/tb_adc_controller.sv
// Directed bench for adc_controller with a behavioural ADC128S022 model.
module tb_adc_controller;
  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        dout;
  logic        adc_sck, adc_cs_n, din;
  logic [11:0] left_value, center_value, right_value;

  adc_controller dut (
    .clk_50M      (clk_50M),
    .rst_n        (rst_n),
    .dout         (dout),
    .adc_sck      (adc_sck),
    .adc_cs_n     (adc_cs_n),
    .din          (din),
    .left_value   (left_value),
    .center_value (center_value),
    .right_value  (right_value)
  );

  always #10 clk_50M = ~clk_50M;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // ---------------- ADC model ----------------
  // Decodes the address from din, answers it one frame later. Not reset by
  // rst_n: after a mid-frame reset it still answers the last full address.
  logic [11:0] chan_data [0:7];
  logic        lead_ones = 1'b0;
  logic        in_frame  = 1'b0;
  logic [3:0]  mb        = '0;
  int          frame_no  = 0;
  logic [2:0]  addr_prev = 3'd0;
  logic [15:0] din_sh    = '0;
  logic [15:0] din_log [0:63];

  always @(posedge adc_sck or negedge adc_sck or posedge adc_cs_n) begin
    logic [11:0] val;
    #1;
    if (adc_cs_n) begin
      in_frame = 1'b0;
      frame_no = 0;
    end else if (adc_sck) begin
      din_sh = {din_sh[14:0], din};
      if (mb == 4'd15) begin
        if (frame_no < 64) din_log[frame_no] = din_sh;
        addr_prev = din_sh[13:11];
      end
    end else begin
      if (!in_frame) begin
        in_frame = 1'b1;
        mb       = 4'd0;
        frame_no = 1;
      end else begin
        mb = mb + 4'd1;
        if (mb == 4'd0) frame_no++;
      end
      val  = chan_data[addr_prev];
      dout = (mb < 4'd4) ? lead_ones : val[15 - int'(mb)];
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input int target);
    int n = 0;
    while (frame_no < target && n < 2000) begin
      @(posedge clk_50M); #3; n++;
    end
    check($sformatf("frame_%0d_reached", target), 64'(frame_no >= target), 64'd1);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (adc_sck === lvl && n < 200) begin
      @(posedge clk_50M); #3; n++;
    end
  endtask

  task automatic check_out(input string tag, input logic [11:0] l, input logic [11:0] c,
                           input logic [11:0] r);
    check({tag, "_left"},   64'(left_value),   64'(l));
    check({tag, "_center"}, 64'(center_value), 64'(c));
    check({tag, "_right"},  64'(right_value),  64'(r));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hi, lo, t_prev;
    for (int i = 0; i < 8; i++) chan_data[i] = 12'hDEA;
    chan_data[5] = 12'hABC;
    chan_data[6] = 12'h123;
    chan_data[7] = 12'h5A5;
    rst_n = 1'b0;
    dout  = 1'b0;

    // reset state
    repeat (4) @(posedge clk_50M);
    #3;
    check("rst_sck",  64'(adc_sck),  64'd0);
    check("rst_cs_n", 64'(adc_cs_n), 64'd1);
    check("rst_din",  64'(din),      64'd0);
    check_out("rst", 12'h000, 12'h000, 12'h000);

    // clock scaler and chip select
    @(negedge clk_50M) rst_n = 1'b1;
    @(posedge clk_50M); #3;
    run_len(1'b0, lo);
    check("cs_high_before_first_fall", 64'(adc_cs_n), 64'd1);
    run_len(1'b1, hi);
    check("sck_high_cycles", 64'(hi), 64'd25);
    check("cs_low_after_first_fall", 64'(adc_cs_n), 64'd0);
    run_len(1'b0, lo);
    check("sck_low_cycles", 64'(lo), 64'd25);
    check_out("idle", 12'h000, 12'h000, 12'h000);

    // first frame discarded, then ch5/6/7 land in turn
    wait_frame(2);
    check_out("f1_discard", 12'h000, 12'h000, 12'h000);
    wait_frame(3);
    check_out("f2", 12'hABC, 12'h000, 12'h000);
    wait_frame(4);
    check_out("f3", 12'hABC, 12'h123, 12'h000);
    check("din_frame1", 64'(din_log[1]), 64'h2800);
    check("din_frame2", 64'(din_log[2]), 64'h3000);
    check("din_frame3", 64'(din_log[3]), 64'h3800);
    wait_frame(5);
    check_out("f4", 12'hABC, 12'h123, 12'h5A5);

    // full-scale extremes on ch6 with leading slots driven high
    lead_ones    = 1'b1;
    chan_data[6] = 12'hFFF;
    wait_frame(6);
    check_out("f5_lead_ones", 12'hABC, 12'h123, 12'h5A5);
    wait_frame(7);
    check_out("f6_fff", 12'hABC, 12'hFFF, 12'h5A5);
    chan_data[6] = 12'h000;
    wait_frame(9);
    check("f8_center_hold", 64'(center_value), 64'hFFF);
    wait_frame(10);
    check_out("f9_zero", 12'hABC, 12'h000, 12'h5A5);

    // reset at n=9 of a frame carrying 777 on ch5
    chan_data[5] = 12'h777;
    begin
      int n = 0;
      while (!(frame_no == 11 && mb == 4'd9) && n < 3000) begin
        @(posedge clk_50M); #3; n++;
      end
      check("reached_n9", 64'(frame_no == 11 && mb == 4'd9), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 64'(adc_cs_n), 64'd1);
    check("midrst_sck",  64'(adc_sck),  64'd0);
    check_out("midrst", 12'h000, 12'h000, 12'h000);
    chan_data[5] = 12'hABC;
    chan_data[6] = 12'h123;
    repeat (5) @(posedge clk_50M);
    @(negedge clk_50M) rst_n = 1'b1;

    // restart behaves as from power-up; stale ch5 answer in frame 1 dropped
    wait_frame(2);
    check_out("rst_f1_discard", 12'h000, 12'h000, 12'h000);
    wait_frame(3);
    check_out("rst_f2", 12'hABC, 12'h000, 12'h000);
    wait_frame(5);
    check_out("rst_f4", 12'hABC, 12'h123, 12'h5A5);

    // long run: frames back to back, outputs stable
    t_prev = cyc;
    for (int i = 0; i < 30; i++) begin
      wait_frame(6 + i);
      check($sformatf("frame_period_%0d", i), 64'(cyc - t_prev), 64'd800);
      check($sformatf("stable_%0d", i), {28'd0, left_value, center_value, right_value},
            {28'd0, 12'hABC, 12'h123, 12'h5A5});
      t_prev = cyc;
    end
    check("long_cs_low", 64'(adc_cs_n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_controller.md
ADC_CONTROLLER -- requirements
Module: adc_controller

Interface
REQ-001 The block SHALL have one clock, clk_50M, and an asynchronous, active-low reset, rst_n; no other clock is used internally.
REQ-002 clk_50M  input  1  50 MHz system clock; all flops on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 dout  input  1  serial data from ADC (ADC128S022-type, 8-ch, 12-bit).
REQ-005 adc_sck  output  1  1 MHz SPI clock to ADC.
REQ-006 adc_cs_n  output  1  ADC chip select, active low.
REQ-007 din  output  1  serial control word to ADC.
REQ-008 left_value  output  12  latest channel-5 conversion.
REQ-009 center_value  output  12  latest channel-6 conversion.
REQ-010 right_value  output  12  latest channel-7 conversion.

Function
REQ-011 Clock scaler SHALL count clk_50M cycles 0..24 and toggle adc_sck when the count is 24, then wrap to 0: high 25 cycles, low 25 cycles, period 50 cycles (1.000 MHz, 50 % duty).
REQ-012 Internal single-cycle strobes sck_rise and sck_fall SHALL mark the clk_50M cycles in which adc_sck toggles 0->1 and 1->0; all SPI logic SHALL use these enables, not adc_sck as a clock.
REQ-013 adc_cs_n SHALL go low on the first sck_fall after reset release and stay low during continuous conversion.
REQ-014 A frame SHALL be 16 adc_sck periods; a 4-bit bit index n (0..15) advances on each sck_rise and wraps 15->0 with no gap between frames.
REQ-015 din SHALL change only on sck_fall; during bit n, din = control word bit (15-n), MSB first.
REQ-016 Control word SHALL be {2'b00, ADD[2:0], 11'b0}, so ADD2/ADD1/ADD0 occupy bits n=2,3,4.
REQ-017 Addresses sent SHALL cycle 5, 6, 7, 5, ... one per frame, starting with 5 in the first frame after reset.
REQ-018 dout SHALL be sampled on sck_rise for n=4..15 and shifted in MSB first (n=4 -> bit 11, n=15 -> bit 0); samples at n=0..3 are ignored.
REQ-019 Data received in frame k SHALL belong to the address sent in frame k-1; the first frame after reset SHALL be discarded and no output updated.
REQ-020 On the sck_rise of n=15, the assembled 12-bit word SHALL be written to the output register of the previous frame's channel (5->left, 6->center, 7->right) on the next clk_50M edge; the other two outputs hold.
REQ-021 Each output SHALL refresh every 3 frames (48 µs); first valid left_value 32 µs after cs_n falls.
REQ-022 Values SHALL be stored unsigned, unmodified; 12'h000 and 12'hFFF are legal and pass through unchanged.

Reset
REQ-023 While rst_n=0: adc_sck=0, adc_cs_n=1, din=0, left/center/right_value=12'h000, scaler count=0, n=0, shift register cleared, address pointer=5, first-frame-discard flag set.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately: no partial word written; after release the sequence restarts exactly as from power-up (REQ-013, REQ-017, REQ-019).

Verification
REQ-025 Reset then idle 2 µs -> adc_sck period 50 clk_50M cycles, high 25/low 25; adc_cs_n low after first sck_fall; all outputs 12'h000.
REQ-026 Monitor din over first three frames -> bits n=2..4 read 101, 110, 111, all other din bits 0.
REQ-027 ADC model returns 12'hABC for ch5, 12'h123 for ch6, 12'h5A5 for ch7 (4 leading zeros, MSB first) -> after frames 2/3/4 left=ABC, center=123, right=5A5; others unchanged at each update.
REQ-028 Model returns 12'hFFF then 12'h000 on ch6 -> center_value = 12'hFFF, then 12'h000 three frames later; leading-zero slots driven 1 do not corrupt results.
REQ-029 Assert rst_n low at n=9 of a frame returning 12'h777 -> outputs 12'h000, cs_n=1 immediately; after release first frame discarded and 12'h777 never appears.
REQ-030 Long run (30 frames) with static model values -> outputs stable, each channel updated exactly every 48 µs, no frame gaps.
